// File: rtl/vproc_if.sv
// Strobe/acknowledge bus between the program-driven master and its BFM wrapper.
// The master drives address, write data and the two strobes; the wrapper answers.
interface vproc_if;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic        we;
  logic        wr_ack;
  logic [31:0] data_in;
  logic        rd;
  logic        rd_ack;

  modport master (
    output addr, data_out, we, rd,
    input  wr_ack, data_in, rd_ack
  );

  modport slave (
    input  addr, data_out, we, rd,
    output wr_ack, data_in, rd_ack
  );
endinterface

// File: rtl/vproc.sv
// Program-driven bus master: fetches 68-bit commands from a per-node bank and
// issues single-word reads/writes, waits, and toggle-handshaked completions.
module vproc #(
  parameter int    PROG_AW   = 8,
  parameter int    NODE_W    = 4,
  parameter string PROG_FILE = "vproc.hex"
) (
  input  logic              clk,
  input  logic              rst,
  vproc_if.master           bus,
  input  logic [2:0]        interrupt,
  output logic              update,
  input  logic              update_response,
  input  logic [NODE_W-1:0] node,
  output logic              halted,
  output logic              error
);

  localparam int MEM_DEPTH = 1 << (NODE_W + PROG_AW);

  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;
  localparam logic [3:0] OP_READCMP = 4'd3;
  localparam logic [3:0] OP_WAIT    = 4'd4;
  localparam logic [3:0] OP_WAITIRQ = 4'd5;
  localparam logic [3:0] OP_JUMP    = 4'd6;
  localparam logic [3:0] OP_HALT    = 4'd7;

  localparam logic [PROG_AW-1:0] PC_ONE = {{(PROG_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH,
    S_BUS,
    S_WAIT,
    S_IRQ,
    S_SYNC,
    S_HALT
  } state_t;

  logic [67:0]        prog_mem_r [MEM_DEPTH];
  state_t             state_r;
  logic [PROG_AW-1:0] pc_r;
  logic [31:0]        addr_r;
  logic [31:0]        dout_r;
  logic               we_r;
  logic               rd_r;
  logic               update_r;
  logic               resp_r;
  logic               halted_r;
  logic               error_r;
  logic [31:0]        rdata_r;
  logic [31:0]        cmp_data_r;
  logic               is_cmp_r;
  logic               cmp_pend_r;
  logic [31:0]        wait_cnt_r;
  logic [2:0]         irq_mask_r;

  logic [67:0]        cmd_s;
  logic [3:0]         op_s;
  logic [31:0]        caddr_s;
  logic [31:0]        cdata_s;

  assign cmd_s   = prog_mem_r[{node, pc_r}];
  assign op_s    = cmd_s[67:64];
  assign caddr_s = cmd_s[63:32];
  assign cdata_s = cmd_s[31:0];

  assign bus.addr     = addr_r;
  assign bus.data_out = dout_r;
  assign bus.we       = we_r;
  assign bus.rd       = rd_r;
  assign update       = update_r;
  assign halted       = halted_r;
  assign error        = error_r;

  // Command sequencer: fetch/decode, bus strobes, waits, and the Update toggle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_FETCH;
      pc_r       <= {PROG_AW{1'b0}};
      addr_r     <= 32'h0000_0000;
      dout_r     <= 32'h0000_0000;
      we_r       <= 1'b0;
      rd_r       <= 1'b0;
      update_r   <= 1'b0;
      resp_r     <= 1'b0;
      halted_r   <= 1'b0;
      error_r    <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      cmp_data_r <= 32'h0000_0000;
      is_cmp_r   <= 1'b0;
      cmp_pend_r <= 1'b0;
      wait_cnt_r <= 32'h0000_0000;
      irq_mask_r <= 3'b000;
    end else begin
      case (state_r)
        S_FETCH: begin
          pc_r <= (op_s == OP_JUMP) ? cdata_s[PROG_AW-1:0] : pc_r + PC_ONE;
          case (op_s)
            OP_WRITE: begin
              addr_r  <= caddr_s;
              dout_r  <= cdata_s;
              we_r    <= 1'b1;
              state_r <= S_BUS;
            end
            OP_READ, OP_READCMP: begin
              addr_r     <= caddr_s;
              rd_r       <= 1'b1;
              is_cmp_r   <= (op_s == OP_READCMP);
              cmp_data_r <= cdata_s;
              state_r    <= S_BUS;
            end
            OP_WAIT: begin
              if (cdata_s == 32'h0000_0000) begin
                update_r <= ~update_r;
                resp_r   <= update_response;
                state_r  <= S_SYNC;
              end else begin
                wait_cnt_r <= cdata_s;
                state_r    <= S_WAIT;
              end
            end
            OP_WAITIRQ: begin
              if (cdata_s[2:0] == 3'b000) begin
                update_r <= ~update_r;
                resp_r   <= update_response;
                state_r  <= S_SYNC;
              end else begin
                irq_mask_r <= cdata_s[2:0];
                state_r    <= S_IRQ;
              end
            end
            OP_HALT: begin
              halted_r <= 1'b1;
              state_r  <= S_HALT;
            end
            default: begin
              // NOP, JUMP and unassigned opcodes complete without an EXEC cycle.
              update_r <= ~update_r;
              resp_r   <= update_response;
              state_r  <= S_SYNC;
            end
          endcase
        end
        S_BUS: begin
          if ((we_r && bus.wr_ack) || (rd_r && bus.rd_ack)) begin
            we_r <= 1'b0;
            rd_r <= 1'b0;
            if (rd_r) begin
              rdata_r    <= bus.data_in;
              cmp_pend_r <= is_cmp_r;
            end else begin
              cmp_pend_r <= 1'b0;
            end
            update_r <= ~update_r;
            resp_r   <= update_response;
            state_r  <= S_SYNC;
          end else begin
            state_r <= S_BUS;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r == 32'd1) begin
            update_r <= ~update_r;
            resp_r   <= update_response;
            state_r  <= S_SYNC;
          end else begin
            wait_cnt_r <= wait_cnt_r - 32'd1;
          end
        end
        S_IRQ: begin
          if ((interrupt & irq_mask_r) != 3'b000) begin
            update_r <= ~update_r;
            resp_r   <= update_response;
            state_r  <= S_SYNC;
          end else begin
            state_r <= S_IRQ;
          end
        end
        S_SYNC: begin
          // Address/data stay valid for the first cycle after the acknowledge, then idle at 0.
          addr_r     <= 32'h0000_0000;
          dout_r     <= 32'h0000_0000;
          cmp_pend_r <= 1'b0;
          if (cmp_pend_r && (rdata_r != cmp_data_r)) begin
            error_r <= 1'b1;
          end else begin
            error_r <= error_r;
          end
          if (update_response != resp_r) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_SYNC;
          end
        end
        S_HALT: begin
          state_r <= S_HALT;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vproc.sv
// Directed bench for vproc: bus timing, read-compare, waits, handshake, bank select,
// PC wrap, asynchronous reset abort and HALT.
module tb_vproc;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] interrupt = 3'b000;
  logic       update;
  logic       update_response;
  logic [3:0] node = 4'd0;
  logic       halted;
  logic       error;
  logic       auto_resp = 1'b1;
  logic       manual_resp = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         w;
  int         toggles;
  int         guard;
  logic       prev;

  vproc_if bus ();

  // A responding wrapper echoes Update straight back; manual mode withholds it.
  assign update_response = auto_resp ? update : manual_resp;

  vproc #(.PROG_AW(8), .NODE_W(4), .PROG_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .interrupt(interrupt),
    .update(update),
    .update_response(update_response),
    .node(node),
    .halted(halted),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts read-strobe cycles, raising RDAck after the strobe has been seen low-acked 3 times.
  task automatic read_width(output int width);
    int g;
    width = 0;
    g = 0;
    while (bus.rd !== 1'b1 && g < 20) begin
      step();
      g++;
    end
    while (bus.rd === 1'b1 && width < 20) begin
      width++;
      if (width == 4) bus.rd_ack = 1'b1;
      step();
    end
    bus.rd_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dut.prog_mem_r[12'h000] = mk(4'd1, 32'h0000_1000, 32'hDEAD_BEEF);
    dut.prog_mem_r[12'h001] = mk(4'd3, 32'h0000_0020, 32'h5A5A_5A5A);
    dut.prog_mem_r[12'h002] = mk(4'd3, 32'h0000_0020, 32'h5A5A_5A5A);
    dut.prog_mem_r[12'h003] = mk(4'd5, 32'h0000_0000, 32'h0000_0004);
    dut.prog_mem_r[12'h004] = mk(4'd4, 32'h0000_0000, 32'h0000_0003);
    dut.prog_mem_r[12'h005] = mk(4'd0, 32'h0000_0000, 32'h0000_0000);
    dut.prog_mem_r[12'h006] = mk(4'd6, 32'h0000_0000, 32'h0000_00FE);
    dut.prog_mem_r[12'h0FE] = mk(4'd0, 32'h0000_0000, 32'h0000_0000);
    dut.prog_mem_r[12'h0FF] = mk(4'd9, 32'h0000_0000, 32'h0000_0000);
    dut.prog_mem_r[12'h100] = mk(4'd1, 32'h0000_1111, 32'h0000_0011);
    dut.prog_mem_r[12'h101] = mk(4'd7, 32'h0000_0000, 32'h0000_0000);
    dut.prog_mem_r[12'h200] = mk(4'd1, 32'h0000_2222, 32'h0000_0022);
    bus.wr_ack  = 1'b1;
    bus.rd_ack  = 1'b0;
    bus.data_in = 32'h0000_0000;
    interrupt   = 3'b011;
    step();
    step();

    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_dout", bus.data_out, 32'h0);
    chk("rst_strobes", {30'h0, bus.we, bus.rd}, 32'h0);
    chk("rst_flags", {29'h0, update, halted, error}, 32'h0);
    chk("rst_rdata", dut.rdata_r, 32'h0);
    chk("rst_pc", {24'h0, dut.pc_r}, 32'h0);

    // WRITE with WRAck tied high: one-cycle strobe, then Update toggles.
    rst = 1'b0;
    step();
    chk("wr_we", {31'h0, bus.we}, 32'h1);
    chk("wr_addr", bus.addr, 32'h0000_1000);
    chk("wr_dout", bus.data_out, 32'hDEAD_BEEF);
    chk("wr_rd_low", {31'h0, bus.rd}, 32'h0);
    chk("wr_upd_pre", {31'h0, update}, 32'h0);
    step();
    chk("wr_we_drop", {31'h0, bus.we}, 32'h0);
    chk("wr_upd", {31'h0, update}, 32'h1);
    chk("wr_addr_hold", bus.addr, 32'h0000_1000);
    step();
    chk("wr_addr_idle", bus.addr, 32'h0);
    chk("wr_dout_idle", bus.data_out, 32'h0);

    // READCMP with matching data, ack delayed 3 cycles.
    bus.data_in = 32'h5A5A_5A5A;
    read_width(w);
    chk("rc1_width", w, 32'd4);
    chk("rc1_upd", {31'h0, update}, 32'h0);
    step();
    step();
    chk("rc1_err", {31'h0, error}, 32'h0);
    chk("rc1_rdata", dut.rdata_r, 32'h5A5A_5A5A);

    // READCMP with differing data sets the sticky Error.
    bus.data_in = 32'h1234_5678;
    read_width(w);
    chk("rc2_width", w, 32'd4);
    chk("rc2_upd", {31'h0, update}, 32'h1);
    step();
    chk("rc2_err", {31'h0, error}, 32'h1);
    chk("rc2_rdata", dut.rdata_r, 32'h1234_5678);

    // WAITIRQ mask 3'b100 stalls on 3'b011 and completes at the edge after 3'b100.
    repeat (8) step();
    chk("irq_stall", {31'h0, update}, 32'h1);
    chk("irq_bus_idle", {30'h0, bus.we, bus.rd}, 32'h0);
    interrupt = 3'b100;
    step();
    chk("irq_done", {31'h0, update}, 32'h0);
    interrupt = 3'b000;

    // WAIT 3 occupies exactly three EXEC cycles after its fetch.
    repeat (4) step();
    chk("wait_busy", {31'h0, update}, 32'h0);
    step();
    chk("wait_done", {31'h0, update}, 32'h1);
    chk("err_sticky", {31'h0, error}, 32'h1);

    // Withheld UpdateResponse blocks the next fetch.
    manual_resp = update;
    auto_resp   = 1'b0;
    step();
    step();
    chk("nop_upd", {31'h0, update}, 32'h0);
    repeat (5) step();
    chk("hold_upd", {31'h0, update}, 32'h0);
    chk("hold_pc", {24'h0, dut.pc_r}, 32'h6);
    manual_resp = ~manual_resp;
    auto_resp   = 1'b1;
    bus.wr_ack  = 1'b0;

    // JUMP to 0xFE, two NOPs, PC wraps, and the program repeats its WRITE.
    prev = update;
    toggles = 0;
    guard = 0;
    while (bus.we !== 1'b1 && guard < 30) begin
      step();
      if (update !== prev) begin
        toggles++;
        prev = update;
      end
      guard++;
    end
    chk("wrap_toggles", toggles, 32'd3);
    chk("wrap_we", {31'h0, bus.we}, 32'h1);
    chk("wrap_addr", bus.addr, 32'h0000_1000);
    chk("wrap_pc", {24'h0, dut.pc_r}, 32'h1);
    step();
    chk("wr_stall", {31'h0, bus.we}, 32'h1);

    // Reset mid-strobe clears the bus before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobes", {30'h0, bus.we, bus.rd}, 32'h0);
    chk("arst_addr", bus.addr, 32'h0);
    chk("arst_dout", bus.data_out, 32'h0);
    chk("arst_flags", {29'h0, update, halted, error}, 32'h0);
    step();
    bus.wr_ack = 1'b1;
    rst = 1'b0;
    step();
    chk("restart_we", {31'h0, bus.we}, 32'h1);
    chk("restart_addr", bus.addr, 32'h0000_1000);

    // Node 1 bank: WRITE then HALT.
    rst = 1'b1;
    node = 4'd1;
    step();
    rst = 1'b0;
    step();
    chk("n1_we", {31'h0, bus.we}, 32'h1);
    chk("n1_addr", bus.addr, 32'h0000_1111);
    chk("n1_dout", bus.data_out, 32'h0000_0011);
    step();
    step();
    step();
    chk("halt_flag", {31'h0, halted}, 32'h1);
    repeat (10) step();
    chk("halt_strobes", {30'h0, bus.we, bus.rd}, 32'h0);
    chk("halt_addr", bus.addr, 32'h0);
    chk("halt_upd", {31'h0, update}, 32'h1);
    chk("halt_keep", {31'h0, halted}, 32'h1);

    // Node 2 bank fetches a distinct program.
    rst = 1'b1;
    node = 4'd2;
    step();
    chk("n2_rst_halt", {31'h0, halted}, 32'h0);
    rst = 1'b0;
    step();
    chk("n2_we", {31'h0, bus.we}, 32'h1);
    chk("n2_addr", bus.addr, 32'h0000_2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
